mmio_stream_port: RTL and testbench

MMIO_STREAM_PORT -- requirements
Module: mmio_stream_port

---
 rtl/mmio_stream_port.sv | 100 ++++++++++
 tb/tb_mmio_stream_port.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_stream_port.sv
// Memory-mapped byte port: a 4-byte register window feeding a TX FIFO that drains
// through a valid/ready stream, with sticky overflow and a wrapping sent-byte count.
module mmio_stream_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  di,
  input  logic        we,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level;
  logic          overflow;
  logic [7:0]    sent;

  logic [15:0] off_full;
  logic [1:0]  off;
  logic        in_win;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        ovf_evt;
  logic        clr_ovf;
  logic        clr_sent;
  logic [7:0]  reg_val;

  // Stream handshake: a byte transfers on every rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_data holds while out_valid && !out_ready.
  assign off_full  = addr - BASE_ADDR;
  assign in_win    = (off_full[15:2] == 14'd0);
  assign off       = off_full[1:0];
  assign empty     = (level == '0);
  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push_req  = we && in_win && (off == 2'd0);
  assign push_ok   = push_req && (!full || pop);
  assign ovf_evt   = push_req && !push_ok;
  assign clr_ovf   = we && in_win && (off == 2'd1) && di[2];
  assign clr_sent  = we && in_win && (off == 2'd3);

  always_comb begin
    reg_val = 8'h00;
    case (off)
      2'd0: reg_val = 8'h00;
      2'd1: reg_val = {5'b0, overflow, full, empty};
      2'd2: reg_val = 8'(level);
      2'd3: reg_val = sent;
      default: reg_val = 8'h00;
    endcase
  end

  // Storage is left uncleared by reset; the pointers alone decide what is queued.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= di;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      sent     <= 8'h00;
      rd_data  <= 8'h00;
      rd_hit   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A dropped push wins over a same-edge clear so no overflow is ever lost.
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (clr_sent)     sent <= 8'h00;
      else if (pop)     sent <= sent + 8'd1;
      rd_data <= (in_win && !we) ? reg_val : 8'h00;
      rd_hit  <= in_win && !we;
    end
  end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Directed bench for mmio_stream_port: register reads, FIFO fill/drain, overflow,
// full-with-pop push, SENT wrap and mid-stream reset, checked against hand-computed values.
module tb_mmio_stream_port;

  localparam logic [15:0] IDLE = 16'h1000;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  di;
  logic        we;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  mmio_stream_port #(.BASE_ADDR(16'hFF00), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .di        (di),
    .we        (we),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change #1 after the edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    di   = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    addr = IDLE;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v, output logic hit);
    addr = a;
    we   = 1'b0;
    tick();
    v    = rd_data;
    hit  = rd_hit;
    addr = IDLE;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] v;
    logic       h;
    bus_read(a, v, h);
    check_eq(tag, v, exp);
    check_eq({tag, "_hit"}, {7'b0, h}, 8'h01);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accepted);
    bus_write(16'hFF00, d);
    if (accepted) exp_q.push_back(d);
  endtask

  // Single pop with out_ready held for exactly one edge; head is checked before it leaves.
  task automatic pop_one(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_model_empty"}, {7'b0, out_valid}, 8'h00);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, {7'b0, out_valid}, 8'h01);
      check_eq(tag, out_data, e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] v;
    logic       h;

    rst = 1'b1; we = 1'b0; addr = IDLE; di = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    check_eq("reset_valid", {7'b0, out_valid}, 8'h00);
    check_eq("reset_hit", {7'b0, rd_hit}, 8'h00);
    check_eq("reset_do", rd_data, 8'h00);
    rst = 1'b0;

    // Status after reset: empty only.
    read_check("status_reset", 16'hFF01, 8'h01);
    read_check("level_reset", 16'hFF02, 8'h00);

    // Two bytes queued, then drained.
    push_byte(8'h0A, 1'b1);
    check_eq("no_bypass_valid", {7'b0, out_valid}, 8'h01);
    check_eq("write_no_hit", {7'b0, rd_hit}, 8'h00);
    push_byte(8'h0B, 1'b1);
    check_eq("head_0a", out_data, 8'h0A);
    read_check("level_2", 16'hFF02, 8'h02);
    read_check("txdata_read", 16'hFF00, 8'h00);
    out_ready = 1'b1;
    check_eq("pop1_data", out_data, 8'h0A);
    tick();
    check_eq("pop2_data", out_data, 8'h0B);
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    check_eq("drained_valid", {7'b0, out_valid}, 8'h00);
    read_check("sent_2", 16'hFF03, 8'h02);
    read_check("status_empty", 16'hFF01, 8'h01);

    // Nine pushes into a depth-8 FIFO: last one dropped, overflow set.
    for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i), i < 8);
    read_check("level_full", 16'hFF02, 8'h08);
    read_check("status_ovf_full", 16'hFF01, 8'h06);
    bus_write(16'hFF01, 8'h04);
    read_check("status_ovf_cleared", 16'hFF01, 8'h02);

    // Full FIFO, pop and push on the same edge: accepted, level holds, no overflow.
    check_eq("full_head", out_data, exp_q[0]);
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    push_byte(8'h19, 1'b1);
    out_ready = 1'b0;
    read_check("level_full_pushpop", 16'hFF02, 8'h08);
    read_check("status_full_noovf", 16'hFF01, 8'h02);
    for (int i = 0; i < 8; i++) pop_one("drain_full");
    check_eq("ninth_absent", {7'b0, out_valid}, 8'h00);
    read_check("sent_11", 16'hFF03, 8'h0B);

    // SENT clear coinciding with a pop ends at zero.
    push_byte(8'h20, 1'b1);
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    bus_write(16'hFF03, 8'hAA);
    out_ready = 1'b0;
    check_eq("clr_pop_valid", {7'b0, out_valid}, 8'h00);
    read_check("sent_clr_pop", 16'hFF03, 8'h00);

    // Stream 255 bytes through, then one more to wrap SENT.
    out_ready = 1'b1;
    for (int k = 0; k < 255; k++) begin
      bus_write(16'hFF00, 8'(k));
      check_eq("stream_head", out_data, 8'(k));
    end
    tick();
    out_ready = 1'b0;
    read_check("sent_255", 16'hFF03, 8'hFF);
    read_check("level_after_stream", 16'hFF02, 8'h00);
    bus_write(16'hFF00, 8'h77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    read_check("sent_wrap", 16'hFF03, 8'h00);

    // Outside the window: no hit, no data, no state change.
    bus_read(16'h0064, v, h);
    check_eq("outside_do", v, 8'h00);
    check_eq("outside_hit", {7'b0, h}, 8'h00);
    bus_write(16'hFF04, 8'h55);
    bus_write(16'hFEFF, 8'h55);
    read_check("outside_no_push", 16'hFF02, 8'h00);

    // Mid-stream reset with a simultaneous write and ready.
    for (int i = 0; i < 6; i++) push_byte(8'(8'h30 + i), 1'b1);
    pop_one("pre_reset_pop");
    read_check("pre_reset_sent", 16'hFF03, 8'h01);
    read_check("pre_reset_level", 16'hFF02, 8'h05);
    rst = 1'b1; we = 1'b1; addr = 16'hFF00; di = 8'h99; out_ready = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; addr = IDLE; out_ready = 1'b0;
    exp_q.delete();
    check_eq("rst_valid", {7'b0, out_valid}, 8'h00);
    check_eq("rst_do", rd_data, 8'h00);
    check_eq("rst_hit", {7'b0, rd_hit}, 8'h00);
    read_check("rst_level", 16'hFF02, 8'h00);
    read_check("rst_sent", 16'hFF03, 8'h00);
    read_check("rst_status", 16'hFF01, 8'h01);
    push_byte(8'h42, 1'b1);
    pop_one("post_reset_pop");
    check_eq("post_reset_empty", {7'b0, out_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
